// File: rtl/run_ctrl.sv
// Run controller for the MIPS core: staggered per-domain reset release, then
// halt/timeout monitoring of the running core with a rotate-XOR WriteData signature.
module run_ctrl #(
    parameter int PC_WIDTH    = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_DOMAINS = 2,
    parameter int RST_HOLD    = 4,
    parameter int STAGGER     = 2,
    parameter int HALT_CYCLES = 8,
    parameter int MAX_CYCLES  = 1024,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PC_WIDTH-1:0]    PCValue,
    input  logic [DATA_WIDTH-1:0]  WriteData,
    output logic [NUM_DOMAINS-1:0] core_rst,
    output logic [1:0]             state,
    output logic [CNT_WIDTH-1:0]   cycle_count,
    output logic [PC_WIDTH-1:0]    last_pc,
    output logic [DATA_WIDTH-1:0]  signature,
    output logic                   halted,
    output logic                   timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [CNT_WIDTH-1:0] HALT_LAST = CNT_WIDTH'(HALT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] MAX_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);

    state_e                 state_q;
    logic [NUM_DOMAINS-1:0] core_rst_q;
    logic [CNT_WIDTH-1:0]   cycle_count_q;
    logic [CNT_WIDTH-1:0]   hold_cnt_q;
    logic [CNT_WIDTH-1:0]   stable_cnt_q;
    logic [PC_WIDTH-1:0]    last_pc_q;
    logic [DATA_WIDTH-1:0]  signature_q;
    logic                   halted_q;
    logic                   timeout_q;

    logic [NUM_DOMAINS-1:0] release_d;
    logic [DATA_WIDTH-1:0]  signature_d;
    logic                   pc_same_d;
    logic                   halt_d;
    logic                   timeout_d;

    // Domain i releases on the edge where hold_cnt reaches RST_HOLD-1+i*STAGGER.
    always_comb begin
        release_d = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            release_d[i] = (hold_cnt_q == CNT_WIDTH'(RST_HOLD - 1 + i * STAGGER));
        end
        signature_d = {signature_q[DATA_WIDTH-2:0], signature_q[DATA_WIDTH-1]} ^ WriteData;
        pc_same_d   = (PCValue == last_pc_q);
        halt_d      = pc_same_d && (stable_cnt_q == HALT_LAST);
        timeout_d   = (cycle_count_q == MAX_LAST);
    end

    // start is a plain level: it is acted on only while the controller is in IDLE or DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            core_rst_q    <= '1;
            cycle_count_q <= '0;
            hold_cnt_q    <= '0;
            stable_cnt_q  <= '0;
            last_pc_q     <= '0;
            signature_q   <= '0;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    core_rst_q <= '1;
                    if (start) begin
                        state_q       <= S_HOLD;
                        hold_cnt_q    <= '0;
                        stable_cnt_q  <= '0;
                        cycle_count_q <= '0;
                        signature_q   <= '0;
                        halted_q      <= 1'b0;
                        timeout_q     <= 1'b0;
                    end
                end
                S_HOLD: begin
                    hold_cnt_q <= hold_cnt_q + 1'b1;
                    last_pc_q  <= PCValue;
                    core_rst_q <= core_rst_q & ~release_d;
                    if (release_d[NUM_DOMAINS-1]) begin
                        state_q      <= S_RUN;
                        stable_cnt_q <= '0;
                    end
                end
                S_RUN: begin
                    cycle_count_q <= cycle_count_q + 1'b1;
                    signature_q   <= signature_d;
                    last_pc_q     <= PCValue;
                    stable_cnt_q  <= pc_same_d ? stable_cnt_q + 1'b1 : '0;
                    // Halt and timeout may coincide; both flags land on one DONE edge.
                    if (halt_d || timeout_d) begin
                        halted_q   <= halt_d;
                        timeout_q  <= timeout_d;
                        core_rst_q <= '1;
                        state_q    <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign core_rst    = core_rst_q;
    assign state       = state_q;
    assign cycle_count = cycle_count_q;
    assign last_pc     = last_pc_q;
    assign signature   = signature_q;
    assign halted      = halted_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: a default instance (reset, stagger, halt, restart) and an
// 8-bit/MAX_CYCLES=16 instance (signature, timeout), checked through an expected-value queue.
module tb_run_ctrl;

  localparam int F_STATE = 0;
  localparam int F_RST   = 1;
  localparam int F_CNT   = 2;
  localparam int F_SIG   = 3;
  localparam int F_PC    = 4;
  localparam int F_HALT  = 5;
  localparam int F_TMO   = 6;

  typedef struct {
    int          cyc;
    int          dut;
    int          fld;
    logic [63:0] exp;
    string       name;
  } sb_t;

  logic clk;
  int   cyc;
  int   n_vec;
  int   n_err;
  sb_t  sb_q[$];
  sb_t  e_mon;
  logic [63:0] act_mon;

  // dut A: default parameters
  logic        a_rst, a_start;
  logic [31:0] a_pc, a_wd;
  logic [1:0]  a_core_rst, a_state;
  logic [31:0] a_cnt, a_last_pc, a_sig;
  logic        a_halted, a_timeout;

  // dut B: 8-bit data, short run budget
  logic        b_rst, b_start;
  logic [31:0] b_pc;
  logic [7:0]  b_wd;
  logic [1:0]  b_core_rst, b_state;
  logic [31:0] b_cnt, b_last_pc;
  logic [7:0]  b_sig;
  logic        b_halted, b_timeout;

  run_ctrl u_dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .PCValue(a_pc), .WriteData(a_wd),
    .core_rst(a_core_rst), .state(a_state), .cycle_count(a_cnt), .last_pc(a_last_pc),
    .signature(a_sig), .halted(a_halted), .timeout(a_timeout)
  );

  run_ctrl #(.DATA_WIDTH(8), .MAX_CYCLES(16)) u_dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .PCValue(b_pc), .WriteData(b_wd),
    .core_rst(b_core_rst), .state(b_state), .cycle_count(b_cnt), .last_pc(b_last_pc),
    .signature(b_sig), .halted(b_halted), .timeout(b_timeout)
  );

  // clock / cycle index
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] observe(input int dut, input int fld);
    logic [63:0] v;
    v = '0;
    if (dut == 0) begin
      case (fld)
        F_STATE: v = 64'(a_state);
        F_RST:   v = 64'(a_core_rst);
        F_CNT:   v = 64'(a_cnt);
        F_SIG:   v = 64'(a_sig);
        F_PC:    v = 64'(a_last_pc);
        F_HALT:  v = 64'(a_halted);
        default: v = 64'(a_timeout);
      endcase
    end else begin
      case (fld)
        F_STATE: v = 64'(b_state);
        F_RST:   v = 64'(b_core_rst);
        F_CNT:   v = 64'(b_cnt);
        F_SIG:   v = 64'(b_sig);
        F_PC:    v = 64'(b_last_pc);
        F_HALT:  v = 64'(b_halted);
        default: v = 64'(b_timeout);
      endcase
    end
    return v;
  endfunction

  // monitor: pops every expectation tagged with the cycle just completed
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e_mon   = sb_q.pop_front();
      act_mon = observe(e_mon.dut, e_mon.fld);
      n_vec++;
      if (e_mon.cyc != cyc || act_mon !== e_mon.exp) begin
        n_err++;
        $display("FAIL %s (dut %0d, cycle %0d): got 0x%0h expected 0x%0h",
                 e_mon.name, e_mon.dut, e_mon.cyc, act_mon, e_mon.exp);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int dut, input int fld, input logic [63:0] v, input string nm);
    sb_q.push_back('{cyc, dut, fld, v, nm});
  endtask

  task automatic set_start(input int dut, input logic v);
    if (dut == 0) a_start = v;
    else          b_start = v;
  endtask

  task automatic expect_reset(input int dut, input string nm);
    expect_v(dut, F_STATE, 0, {nm, "_state"});
    expect_v(dut, F_RST,   3, {nm, "_core_rst"});
    expect_v(dut, F_CNT,   0, {nm, "_cnt"});
    expect_v(dut, F_SIG,   0, {nm, "_sig"});
    expect_v(dut, F_HALT,  0, {nm, "_halted"});
    expect_v(dut, F_TMO,   0, {nm, "_timeout"});
  endtask

  // start pulse at E0, then the six HOLD edges of the default release schedule
  task automatic do_start(input int dut, input string nm);
    set_start(dut, 1'b1);
    tick();
    expect_v(dut, F_STATE, 1, {nm, "_e0_state"});
    expect_v(dut, F_RST,   3, {nm, "_e0_core_rst"});
    expect_v(dut, F_CNT,   0, {nm, "_e0_cnt"});
    expect_v(dut, F_SIG,   0, {nm, "_e0_sig"});
    expect_v(dut, F_HALT,  0, {nm, "_e0_halted"});
    expect_v(dut, F_TMO,   0, {nm, "_e0_timeout"});
    set_start(dut, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      expect_v(dut, F_RST, (k < 4) ? 3 : (k < 6) ? 2 : 0, $sformatf("%s_e%0d_core_rst", nm, k));
      expect_v(dut, F_STATE, (k < 6) ? 1 : 2, $sformatf("%s_e%0d_state", nm, k));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    a_rst = 1'b0; a_start = 1'b0; a_pc = '0; a_wd = '0;
    b_rst = 1'b0; b_start = 1'b0; b_pc = '0; b_wd = '0;

    tick();
    expect_reset(0, "por_a");
    expect_reset(1, "por_b");
    a_rst = 1'b1;
    b_rst = 1'b1;
    tick();
    expect_v(0, F_STATE, 0, "idle_state");
    expect_v(0, F_RST,   3, "idle_core_rst");

    // staggered release, then 10 RUN cycles with start poked mid-run
    a_pc = 32'hFFFC;
    do_start(0, "stagger");
    for (int r = 1; r <= 10; r++) begin
      a_pc    = 32'(4 * (r - 1));
      a_wd    = (r == 1) ? 32'h1 : (r == 2) ? 32'h2 : (r == 3) ? 32'h80 : 32'h0;
      a_start = (r == 5 || r == 6);
      tick();
      expect_v(0, F_CNT, 64'(r), $sformatf("run_cnt_r%0d", r));
      if (r == 1)  expect_v(0, F_SIG, 64'h1, "sig32_r1");
      if (r == 2)  expect_v(0, F_SIG, 64'h0, "sig32_r2");
      if (r == 3)  expect_v(0, F_SIG, 64'h80, "sig32_r3");
      if (r == 10) expect_v(0, F_SIG, 64'h4000, "sig32_r10");
      if (r == 6 || r == 7) expect_v(0, F_STATE, 2, $sformatf("start_in_run_r%0d", r));
      if (r == 10) expect_v(0, F_PC, 64'h24, "last_pc_r10");
    end
    a_start = 1'b0;
    a_rst   = 1'b0;
    tick();
    expect_reset(0, "rst_mid_run");
    a_rst = 1'b1;

    // halt: PC steps by 4 for 20 RUN edges, then parks at 0x50
    a_pc = 32'hFFFC;
    do_start(0, "halt");
    for (int r = 1; r <= 29; r++) begin
      a_pc = (r <= 20) ? 32'(4 * (r - 1)) : 32'h50;
      a_wd = 32'(r);
      tick();
      if (r == 28) begin
        expect_v(0, F_HALT,  0, "halt_r28_halted");
        expect_v(0, F_STATE, 2, "halt_r28_state");
      end
      if (r == 29) begin
        expect_v(0, F_HALT,  1, "halt_r29_halted");
        expect_v(0, F_STATE, 3, "halt_r29_state");
        expect_v(0, F_TMO,   0, "halt_r29_timeout");
        expect_v(0, F_RST,   3, "halt_r29_core_rst");
        expect_v(0, F_CNT,   29, "halt_r29_cnt");
        expect_v(0, F_PC,    64'h50, "halt_r29_last_pc");
      end
    end
    tick();
    expect_v(0, F_STATE, 3, "done_hold_state");
    expect_v(0, F_CNT,   29, "done_hold_cnt");
    expect_v(0, F_HALT,  1, "done_hold_halted");

    // restart from DONE: clearing and identical HOLD timing
    a_pc = 32'hFFFC;
    do_start(0, "restart");

    // dut B: 8-bit signature with rotate wrap, then timeout after 16 RUN edges
    b_pc = 32'hFFFC;
    do_start(1, "b_start");
    for (int r = 1; r <= 16; r++) begin
      b_pc = 32'(4 * r);
      b_wd = (r == 1) ? 8'h01 : (r == 2) ? 8'h02 : (r == 3) ? 8'h80 : 8'h00;
      tick();
      if (r == 1) expect_v(1, F_SIG, 64'h01, "sig8_r1");
      if (r == 2) expect_v(1, F_SIG, 64'h00, "sig8_r2");
      if (r == 3) expect_v(1, F_SIG, 64'h80, "sig8_r3");
      if (r == 4) expect_v(1, F_SIG, 64'h01, "sig8_wrap_r4");
      if (r == 15) begin
        expect_v(1, F_TMO,   0, "tmo_r15_timeout");
        expect_v(1, F_STATE, 2, "tmo_r15_state");
      end
      if (r == 16) begin
        expect_v(1, F_TMO,   1, "tmo_r16_timeout");
        expect_v(1, F_HALT,  0, "tmo_r16_halted");
        expect_v(1, F_CNT,   16, "tmo_r16_cnt");
        expect_v(1, F_STATE, 3, "tmo_r16_state");
        expect_v(1, F_RST,   3, "tmo_r16_core_rst");
      end
    end

    // final report
    tick();
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      n_err += sb_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Synthesisable run controller for the MIPS single-cycle/pipelined core. It replaces ad-hoc bench clock/reset pokes with a parametrised sequencer that:
- holds and releases per-domain core resets in a staggered order;
- monitors the core's PCValue/WriteData to detect a halt (PC self-loop) or a timeout;
- accumulates a WriteData signature for pass/fail comparison.

It sits between the board/bench reset and TopLevel.

## Interface
Parameters:
- PC_WIDTH, 32, width of PCValue and last_pc
- DATA_WIDTH, 32, width of WriteData and signature
- NUM_DOMAINS, 2, number of core reset outputs (≥1)
- RST_HOLD, 4, cycles in HOLD before domain 0 releases (≥1)
- STAGGER, 2, extra cycles between successive domain releases (≥0)
- HALT_CYCLES, 8, consecutive unchanged-PC RUN cycles that declare halt (≥2)
- MAX_CYCLES, 1024, RUN cycle budget before timeout (≥1)
- CNT_WIDTH, 32, width of counters

Ports:
- clk, in, 1, single clock, all state on posedge
- rst, in, 1, synchronous, active-low reset
- start, in, 1, level, sampled in IDLE/DONE only
- PCValue, in, PC_WIDTH, core PC
- WriteData, in, DATA_WIDTH, core register-file write data
- core_rst, out, NUM_DOMAINS, active-high resets to core domains
- state, out, 2, IDLE=0, HOLD=1, RUN=2, DONE=3
- cycle_count, out, CNT_WIDTH, RUN cycles elapsed
- last_pc, out, PC_WIDTH, registered PCValue
- signature, out, DATA_WIDTH, rotate-XOR checksum of WriteData
- halted, out, 1, sticky halt flag
- timeout, out, 1, sticky timeout flag

## Operation
- Reset (rst=0 at posedge, any state, including mid-HOLD/RUN), next state:
  - state=IDLE, core_rst=all 1
  - cycle_count, hold_cnt, stable_cnt, signature, last_pc = 0
  - halted=timeout=0
- IDLE: core_rst all 1. start=1 → HOLD, hold_cnt=0, clear counters/flags/signature.
- HOLD:
  - hold_cnt increments each edge; last_pc<=PCValue.
  - On the edge where hold_cnt==RST_HOLD-1+i*STAGGER: core_rst[i]<=0.
  - Released domains stay 0.
  - With STAGGER=0, all domains release on the same edge.
  - The edge releasing domain NUM_DOMAINS-1 also moves to RUN, clearing stable_cnt.
- RUN, each edge:
  - cycle_count+1
  - signature<={signature[DATA_WIDTH-2:0],signature[DATA_WIDTH-1]}^WriteData
  - last_pc<=PCValue
  - stable_cnt<=(PCValue==last_pc)?stable_cnt+1:0
- Halt: PCValue==last_pc and stable_cnt==HALT_CYCLES-1 → halted<=1, DONE.
- Timeout: cycle_count==MAX_CYCLES-1 → timeout<=1, DONE.
- Halt and timeout on the same edge: both flags set, single transition to DONE.
- The DONE-transition edge still updates cycle_count, signature and last_pc.
- DONE:
  - core_rst<=all 1 (core frozen); all other outputs hold.
  - start=1 → HOLD with the same clearing as from IDLE (restart).
- start is ignored in HOLD and RUN. Counters saturate never; MAX_CYCLES must fit CNT_WIDTH.

## Timing
- All outputs registered; no combinational input→output path.
- start sampled at edge E0 → state=HOLD after E0.
- Defaults: core_rst[0]=0 after E4; core_rst[1]=0 and state=RUN after E6.
- General: RUN entered after edge E0+RST_HOLD+(NUM_DOMAINS-1)*STAGGER.
- First RUN cycle's PCValue/WriteData are sampled on the next edge.
- cycle_count=k after k RUN edges.
- Halt flagged on the HALT_CYCLES-th consecutive RUN edge where PCValue equals the previous sample. A PC change resets the run.
- Latency from the flag edge to core_rst re-assert: same edge (core_rst all 1 after it).

## Test plan
- Reset mid-RUN:
  - Stimulus: defaults, RUN for 10 cycles, then rst=0 for 1 edge.
  - Response: state=0, core_rst=2'b11, cycle_count=0, signature=0, flags 0.
- Staggered release:
  - Stimulus: defaults, start pulse at E0.
  - Response: core_rst 11→10 after E4, →00 after E6, state=2 after E6; core_rst[1] never drops before E6.
- Halt detection:
  - Stimulus: PC increments by 4 from 0x0 for 20 RUN cycles, then holds 0x50.
  - Response: halted=1 and state=3 exactly 8 edges after the first repeated sample; timeout=0; core_rst=11.
- Timeout:
  - Stimulus: MAX_CYCLES=16, PC always increments.
  - Response: after 16 RUN edges, timeout=1, halted=0, cycle_count=16, state=3.
- Signature, DATA_WIDTH=8:
  - Stimulus: WriteData sequence 0x01,0x02,0x80.
  - Response: signature 0x01, 0x00, 0x80.
- Restart from DONE:
  - Stimulus: start=1 from DONE.
  - Response: flags, cycle_count and signature clear; HOLD sequence repeats with identical timing. start asserted during RUN has no effect.
